// File: rtl/white_key_render.sv
// white_key_render
//   Draws the 15 white keys of a keyboard strip into a VGA pixel stream.
//   Note events (press/release) are gathered during a frame. They are
//   committed to the displayed key state in one step, just after vsync_in
//   rises, so a key never changes colour part-way through the visible area.
//
//   Video path: two register stages. The latency from CounterY, key_hit,
//   syncs and blank to vga_r/g/b and the delayed syncs is exactly 2 cycles.
//
//   Optional feature: define WHITE_KEY_FADE_EN to give each key a 4-bit
//   fade counter. A released key then fades from red-ish back to white over
//   15 frames. With the macro undefined, no fade logic exists.
//
// Ports
//   vga_clk     pixel clock, rising edge
//   reset       synchronous, active-high
//   CounterX    pixel column (the key geometry arrives through key_hit)
//   CounterY    pixel row, used for the key band test
//   key_hit     per-key region strobes, bit0 = L_5 ... bit14 = H_5
//   hsync_in, vsync_in, blank_in   raw video timing (blank_in 1 = hidden)
//   note_valid, note_on, note_key  note event (note_on 1 = press)
//   note_ready  event handshake
//   vga_r/g/b   colour output
//   hsync_out, vsync_out, blank_out  timing delayed to match the colour
//
// Handshake: an event is consumed on a rising vga_clk edge when
//   note_valid && note_ready. The source holds note_valid, note_on and
//   note_key stable until that edge. note_ready is low only in the apply
//   cycle that follows a vsync_in rise, and also while reset is applied.
module white_key_render #(
  parameter logic [11:0] KEY_TOP   = 12'd400,
  parameter logic [11:0] KEY_BOT   = 12'd479,
  parameter logic [23:0] PRESS_RGB = 24'hFF0000,
  parameter logic [23:0] BG_RGB    = 24'h202020
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic [11:0] CounterX,
  input  logic [11:0] CounterY,
  input  logic [14:0] key_hit,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        blank_in,
  input  logic        note_valid,
  input  logic        note_on,
  input  logic [3:0]  note_key,
  output logic        note_ready,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        blank_out
);

  // The column is not needed here because the key geometry comes in on key_hit.
  logic unused_counter_x;
  assign unused_counter_x = &{1'b0, CounterX};

  // ---------------- key state and event capture ----------------
  logic [14:0] pressed, pend_set, pend_clr, next_pressed, key_mask;
  logic        vsync_prev, apply, vsync_rise, accept;

  assign vsync_rise   = vsync_in & ~vsync_prev;
  assign accept       = note_valid & note_ready & (note_key <= 4'd14);
  assign key_mask     = 15'd1 << note_key;
  assign next_pressed = (pressed | pend_set) & ~pend_clr;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      vsync_prev <= 1'b0;
      apply      <= 1'b0;
      note_ready <= 1'b0;
      pressed    <= '0;
      pend_set   <= '0;
      pend_clr   <= '0;
    end else begin
      vsync_prev <= vsync_in;
      apply      <= vsync_rise;
      // The ready flag drops for exactly the cycle in which apply is high.
      note_ready <= ~vsync_rise;
      if (apply) begin
        pressed  <= next_pressed;
        pend_set <= '0;
        pend_clr <= '0;
      end else if (accept) begin
        // A later event for the same key overwrites an earlier one.
        if (note_on) begin
          pend_set <= pend_set | key_mask;
          pend_clr <= pend_clr & ~key_mask;
        end else begin
          pend_set <= pend_set & ~key_mask;
          pend_clr <= pend_clr | key_mask;
        end
      end
    end
  end

`ifdef WHITE_KEY_FADE_EN
  logic [3:0] fade [15];
  logic [3:0] fade_sel;

  always_ff @(posedge vga_clk) begin
    for (int k = 0; k < 15; k++) begin
      if (reset) begin
        fade[k] <= 4'd0;
      end else if (apply) begin
        if (next_pressed[k])      fade[k] <= 4'd0;
        else if (pressed[k])      fade[k] <= 4'd15;
        else if (fade[k] != 4'd0) fade[k] <= fade[k] - 4'd1;
      end
    end
  end
`endif

  // ---------------- video pipeline ----------------
  logic [14:0] hit1;
  logic        band1, hs1, vs1, bl1;
  logic        band, multi_hit, hit_pressed;
  logic [23:0] colour, rgb;

  assign band = (CounterY >= KEY_TOP) && (CounterY <= KEY_BOT);

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hit1  <= '0;
      band1 <= 1'b0;
      hs1   <= 1'b0;
      vs1   <= 1'b0;
      bl1   <= 1'b0;
    end else begin
      hit1  <= key_hit;
      band1 <= band;
      hs1   <= hsync_in;
      vs1   <= vsync_in;
      bl1   <= blank_in;
    end
  end

  // Clearing the lowest set bit leaves a nonzero value only when two or
  // more bits are set. That case is a shared edge between two keys.
  assign multi_hit   = |(hit1 & (hit1 - 15'd1));
  assign hit_pressed = |(hit1 & pressed);

`ifdef WHITE_KEY_FADE_EN
  // With a single hit bit, OR-ing the masked counters selects that key's fade.
  always_comb begin
    fade_sel = 4'd0;
    for (int k = 0; k < 15; k++)
      if (hit1[k]) fade_sel = fade_sel | fade[k];
  end
`endif

  always_comb begin
    colour = 24'hFFFFFF;
    if (bl1)                         colour = 24'h000000;
    else if (!band1 || hit1 == '0)   colour = BG_RGB;
    else if (multi_hit)              colour = 24'h000000;
    else if (hit_pressed)            colour = PRESS_RGB;
`ifdef WHITE_KEY_FADE_EN
    else if (fade_sel != 4'd0)
      colour = {8'hFF, 8'hFF - {fade_sel, 4'h0}, 8'hFF - {fade_sel, 4'h0}};
`endif
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rgb       <= 24'h000000;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      blank_out <= 1'b1;
    end else begin
      rgb       <= colour;
      hsync_out <= hs1;
      vsync_out <= vs1;
      blank_out <= bl1;
    end
  end

  assign vga_r = rgb[23:16];
  assign vga_g = rgb[15:8];
  assign vga_b = rgb[7:0];

endmodule

// File: tb/tb_white_key_render.sv
module tb_white_key_render;

  logic        vga_clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] CounterX = '0, CounterY = '0;
  logic [14:0] key_hit = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, blank_in = 1'b0;
  logic        note_valid = 1'b0, note_on = 1'b0;
  logic [3:0]  note_key = '0;
  logic        note_ready;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        hsync_out, vsync_out, blank_out;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference state, kept frame by frame.
  bit       model_pressed [15];
  int       model_fade [15];
  int       last_evt [15];        // -1 none, 0 release, 1 press
  logic [26:0] exp_q [$];

  white_key_render dut (
    .vga_clk(vga_clk), .reset(reset), .CounterX(CounterX), .CounterY(CounterY),
    .key_hit(key_hit), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .blank_in(blank_in), .note_valid(note_valid), .note_on(note_on),
    .note_key(note_key), .note_ready(note_ready), .vga_r(vga_r),
    .vga_g(vga_g), .vga_b(vga_b), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .blank_out(blank_out)
  );

  // ---------------- clock / reset ----------------
  always #5 vga_clk = ~vga_clk;

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  task automatic model_clear();
    for (int k = 0; k < 15; k++) begin
      model_pressed[k] = 0;
      model_fade[k] = 0;
      last_evt[k] = -1;
    end
  endtask

  task automatic model_apply();
    for (int k = 0; k < 15; k++) begin
      bit was = model_pressed[k];
      if (last_evt[k] == 1) model_pressed[k] = 1;
      else if (last_evt[k] == 0) model_pressed[k] = 0;
`ifdef WHITE_KEY_FADE_EN
      if (model_pressed[k]) model_fade[k] = 0;
      else if (was) model_fade[k] = 15;
      else if (model_fade[k] > 0) model_fade[k] = model_fade[k] - 1;
`else
      if (was) model_fade[k] = 0;
`endif
      last_evt[k] = -1;
    end
  endtask

  function automatic logic [23:0] exp_rgb(input int y, input logic [14:0] hit,
                                          input logic blank);
    int k;
    int g;
    if (blank) return 24'h000000;
    if (y < 400 || y > 479 || hit == 0) return 24'h202020;
    if ($countones(hit) > 1) return 24'h000000;
    k = 0;
    for (int i = 0; i < 15; i++) if (hit[i]) k = i;
    if (model_pressed[k]) return 24'hFF0000;
    if (model_fade[k] != 0) begin
      g = 255 - model_fade[k] * 16;
      return {8'hFF, 8'(g), 8'(g)};
    end
    return 24'hFFFFFF;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_event(input logic on, input int key);
    bit done = 0;
    note_valid = 1'b1;
    note_on = on;
    note_key = 4'(key);
    for (int i = 0; i < 10; i++) begin
      if (note_ready) begin
        step();
        done = 1;
        break;
      end
      step();
    end
    note_valid = 1'b0;
    tests_run++;
    if (!done) begin
      tests_failed++;
      $display("FAIL event_accept key=%0d: note_ready never high, required accept within 10 cycles", key);
    end else if (key <= 14) begin
      last_evt[key] = on ? 1 : 0;
    end
  endtask

  task automatic do_vsync();
    vsync_in = 1'b0;
    step();
    vsync_in = 1'b1;
    step();
    tests_run++;
    if (note_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL apply_ready: note_ready=%b required 0", note_ready);
    end
    step();
    model_apply();
    vsync_in = 1'b0;
  endtask

  task automatic render_check(input string name, input int y,
                              input logic [14:0] hit, input logic blank);
    logic [23:0] exp, got;
    CounterY = 12'(y);
    CounterX = 12'($urandom_range(0, 639));
    key_hit = hit;
    blank_in = blank;
    exp = exp_rgb(y, hit, blank);
    step();
    step();
    got = {vga_r, vga_g, vga_b};
    tests_run++;
    if (got !== exp || blank_out !== blank) begin
      tests_failed++;
      $display("FAIL %s: rgb=%h blank_out=%b required rgb=%h blank_out=%b",
               name, got, blank_out, exp, blank);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    tests_run++;
    if ({vga_r, vga_g, vga_b} !== 24'h0 || hsync_out !== 1'b0 ||
        vsync_out !== 1'b0 || blank_out !== 1'b1 || note_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: rgb=%h hs=%b vs=%b blank=%b ready=%b required 000000 0 0 1 0",
               {vga_r, vga_g, vga_b}, hsync_out, vsync_out, blank_out, note_ready);
    end
    reset = 1'b0;
    model_clear();
    step();
    tests_run++;
    if (note_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready: note_ready=%b required 1", note_ready);
    end
  endtask

  task automatic test_band_priority();
    render_check("band_top", 400, 15'h0001, 1'b0);
    render_check("above_band", 399, 15'h0001, 1'b0);
    render_check("shared_edge", 400, 15'h0003, 1'b0);
    render_check("band_bot", 479, 15'h4000, 1'b0);
    render_check("below_band", 480, 15'h4000, 1'b0);
    render_check("no_hit", 440, 15'h0000, 1'b0);
    render_check("blanked", 440, 15'h0010, 1'b1);
  endtask

  task automatic test_frame_apply();
    send_event(1'b1, 3);
    render_check("key3_before_vsync", 450, 15'h0008, 1'b0);
    do_vsync();
    render_check("key3_after_vsync", 450, 15'h0008, 1'b0);
    send_event(1'b0, 3);
    do_vsync();
  endtask

  task automatic test_last_wins();
    send_event(1'b1, 5);
    send_event(1'b0, 5);
    send_event(1'b1, 15);
    do_vsync();
    for (int k = 0; k < 15; k++)
      render_check("last_wins_scan", 420, 15'(1 << k), 1'b0);
  endtask

  task automatic test_event_in_apply();
    vsync_in = 1'b0;
    step();
    vsync_in = 1'b1;
    step();
    model_apply();
    note_valid = 1'b1;
    note_on = 1'b1;
    note_key = 4'd7;
    tests_run++;
    if (note_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL apply_cycle_ready: note_ready=%b required 0", note_ready);
    end
    step();
    tests_run++;
    if (note_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL post_apply_ready: note_ready=%b required 1", note_ready);
    end
    step();
    note_valid = 1'b0;
    vsync_in = 1'b0;
    last_evt[7] = 1;
    render_check("key7_same_frame", 430, 15'h0080, 1'b0);
    do_vsync();
    render_check("key7_next_frame", 430, 15'h0080, 1'b0);
    send_event(1'b0, 7);
    do_vsync();
  endtask

  task automatic test_reset_mid_frame();
    send_event(1'b1, 2);
    reset = 1'b1;
    step();
    tests_run++;
    if ({vga_r, vga_g, vga_b} !== 24'h0 || blank_out !== 1'b1 || note_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_outputs: rgb=%h blank=%b ready=%b required 000000 1 0",
               {vga_r, vga_g, vga_b}, blank_out, note_ready);
    end
    reset = 1'b0;
    model_clear();
    step();
    do_vsync();
    render_check("key2_after_reset", 460, 15'h0004, 1'b0);
  endtask

  task automatic test_fade();
    send_event(1'b1, 0);
    do_vsync();
    render_check("fade_pressed", 420, 15'h0001, 1'b0);
    send_event(1'b0, 0);
    do_vsync();
`ifdef WHITE_KEY_FADE_EN
    tests_run++;
    if (model_fade[0] != 15) begin
      tests_failed++;
      $display("FAIL fade_model_start: fade=%0d required 15", model_fade[0]);
    end
`endif
    for (int f = 0; f < 16; f++) begin
      render_check("fade_frame", 420, 15'h0001, 1'b0);
      do_vsync();
    end
  endtask

  // Random pixel stream, back to back, against random key states.
  task automatic test_back_to_back();
    logic [14:0] hit;
    logic [26:0] e, got;
    int y;
    for (int round = 0; round < 3; round++) begin
      for (int n = 0; n < 8; n++)
        send_event(1'($urandom_range(0, 1)), $urandom_range(0, 15));
      do_vsync();
      exp_q.delete();
      for (int c = 0; c < 120; c++) begin
        case ($urandom_range(0, 3))
          0: hit = '0;
          1: hit = 15'(1 << $urandom_range(0, 14));
          2: hit = 15'(3 << $urandom_range(0, 13));
          default: hit = 15'($urandom());
        endcase
        y = $urandom_range(395, 485);
        CounterY = 12'(y);
        CounterX = 12'($urandom_range(0, 639));
        key_hit = hit;
        blank_in = ($urandom_range(0, 7) == 0);
        hsync_in = 1'($urandom_range(0, 1));
        exp_q.push_back({blank_in, 1'b0, hsync_in, exp_rgb(y, hit, blank_in)});
        step();
        if (exp_q.size() >= 2) begin
          e = exp_q.pop_front();
          got = {blank_out, vsync_out, hsync_out, vga_r, vga_g, vga_b};
          tests_run++;
          if (got !== e) begin
            tests_failed++;
            $display("FAIL stream round=%0d cycle=%0d: got=%h required=%h", round, c, got, e);
          end
        end
      end
      step();
      e = exp_q.pop_front();
      got = {blank_out, vsync_out, hsync_out, vga_r, vga_g, vga_b};
      tests_run++;
      if (got !== e) begin
        tests_failed++;
        $display("FAIL stream_flush round=%0d: got=%h required=%h", round, got, e);
      end
      hsync_in = 1'b0;
      blank_in = 1'b0;
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    model_clear();
    test_reset();
    test_band_priority();
    test_frame_apply();
    test_last_wins();
    test_event_in_apply();
    test_reset_mid_frame();
    test_fade();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
